// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file: machine-mode CSR responder for the RV32IM core.
//
// Takes the decoded CSR strobes and operands from the execute stage and
// returns the old CSR value for write-back to rd. The read-modify-write
// update happens on the rising clock edge. The block also holds the 64-bit
// cycle/instret counters and the trap registers used by the PC/trap logic.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   is_csr          SYSTEM-opcode CSR instruction in execute
//   csr_read_en     read strobe (an access is valid when is_csr & csr_read_en)
//   csr_write_en    write strobe
//   funct3          001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//   csr_addr        CSR address (instr[31:20])
//   rs1_idx         rs1 index, also used as zimm by the immediate forms
//   rs1_data        register source operand
//   retire          one pulse per retired instruction
//   trap_en         trap entry pulse, with trap_pc / trap_cause
//   mret_en         MRET executed
//   csr_rdata       old CSR value (combinational, 0 when invalid or illegal)
//   illegal_csr     illegal access (combinational)
//   mtvec_o, mepc_o, mie_o   registered trap state
//
// Handshake: there is no backpressure. Every cycle in which is_csr and
// csr_read_en are both high is one complete access. The read result comes
// out in the same cycle, and any write commits on the next rising edge.
// ---------------------------------------------------------------------------
module csr_file #(
  parameter logic [31:0] HART_ID  = 32'h0,
  parameter logic [31:0] MISA_VAL = 32'h4000_1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_csr,
  input  logic        csr_read_en,
  input  logic        csr_write_en,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic        retire,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_en,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  // Architectural state
  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  // Decode / datapath
  logic        w_valid;
  logic        w_mapped;
  logic [31:0] w_old;
  logic [31:0] w_src;
  logic [31:0] w_new;
  logic        w_op_ok;
  logic        w_wants_write;
  logic        w_ro_violation;
  logic        w_illegal;
  logic        w_we;
  logic        w_trap_busy;

  assign w_valid = is_csr & csr_read_en;
  assign w_src   = funct3[2] ? {27'b0, rs1_idx} : rs1_data;
  assign w_op_ok = (funct3[1:0] != 2'b00);

  // RW/RWI always writes. RS/RC with x0 or zimm=0 is a pure read.
  assign w_wants_write  = ~funct3[1] | (rs1_idx != 5'd0);
  assign w_ro_violation = (csr_addr[11:10] == 2'b11) & w_wants_write;

  assign w_illegal = w_valid & (~w_op_ok | ~w_mapped | w_ro_violation);
  assign w_we      = w_valid & csr_write_en & ~w_illegal
                   & ~(funct3[1] & (rs1_idx == 5'd0));

  // Trap entry and MRET both own mstatus/mepc/mcause in their cycle, so a
  // CSR write to those three is dropped then. Writes elsewhere still commit.
  assign w_trap_busy = trap_en | mret_en;

  // Read mux. The counter shadows alias the machine counters.
  always_comb begin
    w_mapped = 1'b1;
    w_old    = 32'h0;
    case (csr_addr)
      A_MSTATUS:               w_old = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};
      A_MISA:                  w_old = MISA_VAL;
      A_MTVEC:                 w_old = r_mtvec;
      A_MSCRATCH:              w_old = r_mscratch;
      A_MEPC:                  w_old = r_mepc;
      A_MCAUSE:                w_old = r_mcause;
      A_MCYCLE,   A_CYCLE:     w_old = r_mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:    w_old = r_mcycle[63:32];
      A_MINSTRET, A_INSTRET:   w_old = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: w_old = r_minstret[63:32];
      A_MHARTID:               w_old = HART_ID;
      default:                 w_mapped = 1'b0;
    endcase
  end

  always_comb begin
    w_new = w_src;
    case (funct3[1:0])
      2'b10:   w_new = w_old | w_src;
      2'b11:   w_new = w_old & ~w_src;
      default: w_new = w_src;
    endcase
  end

  assign csr_rdata   = (w_valid & ~w_illegal) ? w_old : 32'h0;
  assign illegal_csr = w_illegal;

  // mstatus, mepc, mcause: trap > mret > CSR write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
    end else if (trap_en) begin
      r_mepc   <= trap_pc & ~32'h3;
      r_mcause <= trap_cause;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (mret_en) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_we) begin
      case (csr_addr)
        A_MSTATUS: begin
          r_mie  <= w_new[3];
          r_mpie <= w_new[7];
        end
        A_MEPC:   r_mepc   <= {w_new[31:2], 2'b00};
        A_MCAUSE: r_mcause <= w_new;
        default: ;
      endcase
    end
  end

  // mtvec (direct mode only) and mscratch are not touched by trap/MRET
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtvec    <= 32'h0;
      r_mscratch <= 32'h0;
    end else if (w_we) begin
      if (csr_addr == A_MTVEC)    r_mtvec    <= {w_new[31:2], 2'b00};
      if (csr_addr == A_MSCRATCH) r_mscratch <= w_new;
    end
  end

  // Counters: a write to either half suppresses the increment for the whole
  // 64-bit counter in that cycle, so the other half simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle <= 64'h0;
    end else if (w_we && csr_addr == A_MCYCLE) begin
      r_mcycle[31:0] <= w_new;
    end else if (w_we && csr_addr == A_MCYCLEH) begin
      r_mcycle[63:32] <= w_new;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_minstret <= 64'h0;
    end else if (w_we && csr_addr == A_MINSTRET) begin
      r_minstret[31:0] <= w_new;
    end else if (w_we && csr_addr == A_MINSTRETH) begin
      r_minstret[63:32] <= w_new;
    end else if (retire) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_mie;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// Testbench for csr_file. Inputs are driven on the falling edge. The
// combinational outputs are checked 1 ns later, and registered outputs are
// checked at the following falling edge. Each expected value is pushed into
// exp_q as the stimulus is applied, then popped by chk() when the DUT output
// is sampled.
// ---------------------------------------------------------------------------
module tb_csr_file;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        is_csr, csr_read_en, csr_write_en;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic        retire, trap_en, mret_en;
  logic [31:0] trap_pc, trap_cause;
  logic [31:0] csr_rdata, mtvec_o, mepc_o;
  logic        illegal_csr, mie_o;

  csr_file dut (
    .clk          (clk),
    .rst          (rst),
    .is_csr       (is_csr),
    .csr_read_en  (csr_read_en),
    .csr_write_en (csr_write_en),
    .funct3       (funct3),
    .csr_addr     (csr_addr),
    .rs1_idx      (rs1_idx),
    .rs1_data     (rs1_data),
    .retire       (retire),
    .trap_en      (trap_en),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause),
    .mret_en      (mret_en),
    .csr_rdata    (csr_rdata),
    .illegal_csr  (illegal_csr),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_o        (mie_o)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RCI = 3'b111, RSI = 3'b110;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // Driver tasks
  task automatic idle();
    is_csr = 1'b0; csr_read_en = 1'b0; csr_write_en = 1'b0;
    funct3 = 3'b000; csr_addr = 12'h0; rs1_idx = 5'd0; rs1_data = 32'h0;
    retire = 1'b0; trap_en = 1'b0; mret_en = 1'b0;
    trap_pc = 32'h0; trap_cause = 32'h0;
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] a,
                     input logic [4:0] idx, input logic [31:0] d);
    is_csr = 1'b1; csr_read_en = 1'b1; csr_write_en = 1'b1;
    funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  // Pure read: RS with x0 never writes
  task automatic rd(input logic [11:0] a);
    csr(RS, a, 5'd0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    #2;
    exp_q.push_back(32'h0); chk("reset_mtvec", mtvec_o);
    exp_q.push_back(32'h0); chk("reset_mepc", mepc_o);
    exp_q.push_back(32'h0); chk("reset_mie", {31'b0, mie_o});
    @(negedge clk);
    rst = 1'b0;

    // mscratch: the write is not visible in its own cycle
    exp_q.push_back(32'h0);
    csr(RW, 12'h340, 5'd1, 32'hDEAD_BEEF); chk("mscratch_rw_old", csr_rdata);
    tick();
    exp_q.push_back(32'hDEAD_BEEF);
    rd(12'h340); chk("mscratch_read", csr_rdata);
    tick();
    exp_q.push_back(32'hDEAD_BEEF);
    rd(12'h340); chk("mscratch_rs_x0_nowrite", csr_rdata);
    tick();

    // mtvec: low bits hardwired to zero
    csr(RW, 12'h305, 5'd1, 32'h8000_0003);
    tick();
    exp_q.push_back(32'h8000_0000); chk("mtvec_o", mtvec_o);
    exp_q.push_back(32'h8000_0000);
    csr(RCI, 12'h305, 5'd0, 32'h0); chk("mtvec_rci0_read", csr_rdata);
    tick();
    exp_q.push_back(32'h8000_0000); chk("mtvec_rci0_nowrite", mtvec_o);

    // misa / mhartid
    exp_q.push_back(32'h4000_1100);
    csr(RW, 12'h301, 5'd1, 32'h0); chk("misa_read", csr_rdata);
    exp_q.push_back(32'h0); chk("misa_write_legal", {31'b0, illegal_csr});
    tick();
    exp_q.push_back(32'h4000_1100);
    rd(12'h301); chk("misa_unchanged", csr_rdata);
    tick();
    exp_q.push_back(32'h0);
    rd(12'hF14); chk("mhartid_legal", {31'b0, illegal_csr});
    tick();

    // mepc low bits
    csr(RW, 12'h341, 5'd1, 32'h0000_1003);
    tick();
    exp_q.push_back(32'h0000_1000); chk("mepc_align", mepc_o);

    // mstatus / trap / mret
    exp_q.push_back(32'h0);
    csr(RSI, 12'h300, 5'd8, 32'h0); chk("mstatus_rsi_old", csr_rdata);
    tick();
    exp_q.push_back(32'h1); chk("mie_set", {31'b0, mie_o});
    trap_en = 1'b1; trap_pc = 32'h104; trap_cause = 32'hB;
    tick();
    exp_q.push_back(32'h104); chk("trap_mepc", mepc_o);
    exp_q.push_back(32'h0);   chk("trap_mie", {31'b0, mie_o});
    exp_q.push_back(32'hB);
    rd(12'h342); chk("trap_mcause", csr_rdata);
    tick();
    exp_q.push_back(32'h80);
    rd(12'h300); chk("trap_mstatus", csr_rdata);
    tick();
    mret_en = 1'b1;
    tick();
    exp_q.push_back(32'h1); chk("mret_mie", {31'b0, mie_o});
    exp_q.push_back(32'h88);
    rd(12'h300); chk("mret_mstatus", csr_rdata);
    tick();

    // mcycle carry: low write, then high write (low holds), then two increments
    csr(RW, 12'hB00, 5'd1, 32'hFFFF_FFFE);
    tick();
    csr(RW, 12'hB80, 5'd1, 32'h0);
    tick();
    exp_q.push_back(32'hFFFF_FFFE);
    rd(12'hB00); chk("mcycle_hold_on_h_write", csr_rdata);
    tick();
    tick();
    exp_q.push_back(32'h0);
    rd(12'hB00); chk("mcycle_wrap_lo", csr_rdata);
    tick();
    exp_q.push_back(32'h1);
    rd(12'hB80); chk("mcycle_carry_hi", csr_rdata);
    tick();

    // minstret
    csr(RW, 12'hB02, 5'd1, 32'h5);
    tick();
    repeat (3) begin
      retire = 1'b1;
      tick();
    end
    exp_q.push_back(32'h8);
    rd(12'hB02); chk("instret_plus3", csr_rdata);
    tick();
    csr(RW, 12'hB02, 5'd1, 32'h50);
    retire = 1'b1;
    tick();
    exp_q.push_back(32'h50);
    rd(12'hC02); chk("instret_write_wins", csr_rdata);
    tick();
    exp_q.push_back(32'h0);
    rd(12'hC82); chk("instreth", csr_rdata);
    tick();

    // Read-only shadows and unmapped addresses
    csr(RW, 12'hB00, 5'd1, 32'd100);
    tick();
    exp_q.push_back(32'h1);
    csr(RW, 12'hC00, 5'd1, 32'h0); chk("cycle_rw_illegal", {31'b0, illegal_csr});
    exp_q.push_back(32'h0); chk("cycle_rw_rdata0", csr_rdata);
    tick();
    exp_q.push_back(32'd101);
    rd(12'hC00); chk("cycle_read_counting", csr_rdata);
    exp_q.push_back(32'h0); chk("cycle_read_legal", {31'b0, illegal_csr});
    tick();
    exp_q.push_back(32'h1);
    csr(RW, 12'h7C0, 5'd1, 32'h0); chk("unmapped_illegal", {31'b0, illegal_csr});
    tick();
    exp_q.push_back(32'h1);
    csr(3'b000, 12'h340, 5'd1, 32'h0); chk("funct3_000_illegal", {31'b0, illegal_csr});
    tick();

    // Trap beats a same-cycle mepc write
    trap_en = 1'b1; trap_pc = 32'h300; trap_cause = 32'h2;
    csr(RW, 12'h341, 5'd1, 32'h200);
    tick();
    exp_q.push_back(32'h300); chk("trap_over_write_mepc", mepc_o);

    // Asynchronous reset mid-instruction
    csr(RW, 12'h340, 5'd1, 32'h1234);
    rst = 1'b1;
    #1;
    exp_q.push_back(32'h0); chk("async_rst_mtvec", mtvec_o);
    exp_q.push_back(32'h0); chk("async_rst_mepc", mepc_o);
    exp_q.push_back(32'h0); chk("async_rst_mie", {31'b0, mie_o});
    @(negedge clk);
    rst = 1'b0;
    idle();
    exp_q.push_back(32'h0);
    rd(12'h340); chk("rst_drops_write", csr_rdata);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR responder for the RV32IM core.
- Consumes the decoded CSR strobes (is_csr, csr_read_en, csr_write_en, funct3) plus the CSR address and source operand from the execute stage.
- Returns the old CSR value for write-back to rd, and performs read-modify-write updates on the clock edge.
- Owns the cycle/instret counters and the trap registers (mstatus, mtvec, mepc, mcause) consumed by the PC/trap logic.

Parameters:
- HART_ID, 32'h0, value returned by mhartid (0xF14).
- MISA_VAL, 32'h40001100, value returned by misa (0x301): RV32, I and M.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- is_csr  in  1  SYSTEM-opcode CSR instruction in execute.
- csr_read_en  in  1  read strobe from the control unit.
- csr_write_en  in  1  write strobe from the control unit.
- funct3  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_addr  in  12  instr[31:20].
- rs1_idx  in  5  instr[19:15]; also serves as zimm for immediate ops.
- rs1_data  in  32  register source operand.
- retire  in  1  one pulse per retired instruction.
- trap_en  in  1  trap entry pulse.
- trap_pc  in  32  PC of the trapping instruction.
- trap_cause  in  32  mcause value.
- mret_en  in  1  MRET executed.
- csr_rdata  out  32  old CSR value for rd (combinational).
- illegal_csr  out  1  illegal access (combinational).
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- mie_o  out  1  mstatus.MIE.

Behaviour:
- Reset (async, rst=1): every register clears to 0, including the counters. Resulting outputs: mtvec_o=0, mepc_o=0, mie_o=0.
- Access is valid when is_csr & csr_read_en.
- Read path:
  - csr_rdata is combinational from csr_addr and is 0 when the access is not valid.
  - The value is always the pre-update value, so the write of the same cycle is not visible.
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are implemented; all other bits read 0 and ignore writes.
  - misa 0x301: constant; writes are ignored (WARL) and are not illegal.
  - mtvec 0x305: bits[1:0] are hardwired to 0 (direct mode).
  - mscratch 0x340: full 32-bit read/write.
  - mepc 0x341: bits[1:0] are hardwired to 0.
  - mcause 0x342: full 32-bit read/write.
  - mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82: read/write.
  - cycle 0xC00 / cycleh 0xC80, instret 0xC02 / instreth 0xC82: read-only shadows of the counters.
  - mhartid 0xF14: read-only, returns HART_ID.
- Source operand: src = funct3[2] ? {27'b0, rs1_idx} : rs1_data.
- New value by funct3[1:0]:
  - 01: src.
  - 10: old | src.
  - 11: old & ~src.
- Write enable: we = valid & csr_write_en & ~illegal_csr & ~(funct3[1] & rs1_idx==0). RS/RC with x0 or zimm=0 performs no write.
- illegal_csr=1 when valid and any of the following holds:
  - funct3 is 000 or 100;
  - csr_addr is unmapped;
  - csr_addr[11:10]==2'b11 and the op would write (RW/RWI always counts as a write; RS/RC only when rs1_idx!=0).
  - On an illegal access: no state change, csr_rdata=0.
- Counters (64-bit):
  - mcycle increments every cycle.
  - minstret increments when retire=1.
  - A CSR write to either half in the same cycle wins over the increment for the whole counter. That cycle: written half <= new value, other half holds (no increment, no carry).
  - Otherwise the counter is a 64-bit increment with carry into the high half; wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
- Trap entry (trap_en):
  - mepc <= trap_pc & ~3, mcause <= trap_cause.
  - MPIE <= MIE, MIE <= 0.
- MRET (mret_en): MIE <= MPIE, MPIE <= 1.
- Priority: trap_en > mret_en > CSR write, applied to mstatus/mepc/mcause. A CSR write to any other CSR in the same cycle still commits. Counters are unaffected by trap and MRET.
- Output timing: mtvec_o, mepc_o and mie_o reflect the registered values; updates are visible the cycle after the edge.
- rst asserted mid-instruction: the pending write is dropped and all state is 0 immediately.

Test Plan:
- Reset, then CSRRW 0x340 with rs1_data=0xDEADBEEF -> csr_rdata=0 that cycle. Next cycle CSRRS 0x340 with rs1_idx=0 -> csr_rdata=0xDEADBEEF, no write.
- mtvec: CSRRW 0x305 with 0x8000_0003 -> reads back 0x8000_0000 and mtvec_o=0x8000_0000. Then CSRRCI 0x305 with zimm=0 -> no write, value unchanged.
- mstatus: CSRRSI 0x300 zimm=8 -> mie_o=1. Then trap_en with trap_pc=0x104, cause=0xB -> mepc_o=0x104, mcause=0xB, mie_o=0, mstatus reads 0x80. Then mret_en -> mie_o=1, mstatus reads 0x88.
- Counters: write mcycle=0xFFFF_FFFE, mcycleh=0 -> two cycles later mcycleh=1, mcycle=0. Pulse retire 3 times -> instret increases by 3. Retire in the same cycle as a minstret write -> the written value holds with no increment.
- Read-only: CSRRW 0xC00 -> illegal_csr=1, counter keeps counting. CSRRS 0xC00 with rs1_idx=0 -> legal, returns cycle. CSRRW 0x7C0 (unmapped) -> illegal_csr=1.
- Simultaneous trap_en and CSRRW 0x341 with 0x200, trap_pc=0x300 -> mepc=0x300. Assert rst mid-stream -> all outputs 0 without waiting for a clock edge.
